link_sync_tx: RTL and testbench
===============================

Name: link_sync_tx

Overview:
- Clocked transmitter for the dual-rail asynchronous link protocol used by the self-timed datapath blocks.
- Accepts words on a synchronous valid/ready port and drives them onto a link as dual-rail tokens.
- Supports two-phase ("TP") or four-phase ("FP") encoding, and completes each token by observing the receiver's ack.
- Sits at the clocked boundary, replacing hand-toggled link stimulus. It is the sending end of the protocol the async adders and datapath consume.

Parameters:
- ENC, "TP", link encoding: "TP" = two-phase transition dual-rail, "FP" = four-phase return-to-zero dual-rail. Any other value is an elaboration error.
- WIDTH, 1, data bits per token.
- SYNC_STAGES, 2, flops in the ack synchronizer. Must be ≥2.
- TIMEOUT, 1024, cycles allowed waiting on any ack edge before err is set. 0 disables the timeout.

Ports:
- clk  in  1  clock
- rst_n  in  1  asynchronous active-low reset
- in_data  in  WIDTH  word to send
- in_valid  in  1  in_data is valid
- in_ready  out  1  block accepts in_data this cycle
- link_data  out  2*WIDTH  dual-rail rails; bit i uses rail0 at index 2i and rail1 at index 2i+1
- link_ack  in  1  asynchronous ack from the receiver
- busy  out  1  a token is in flight
- err  out  1  sticky ack-timeout flag

Behaviour:
- Reset (async assert, sync deassert at next clk):
  - link_data=0, in_ready=0, busy=0, err=0.
  - phase=0, timeout counter=0, ack synchronizer=0, state=IDLE.
  - in_ready rises the first cycle after reset release.
- link_ack passes through the SYNC_STAGES flop chain to give ack_s. Only ack_s is used.
- link_data is driven only from flops. No combinational path from any input to link_data.
- States: IDLE, WAIT_SET, RTZ, WAIT_CLR. RTZ and WAIT_CLR are used only when ENC="FP".
- IDLE:
  - in_ready=1, busy=0.
  - Transfer when in_valid & in_ready. The new link_data is visible on the next edge, which is the 1-cycle launch latency.
  - TP on transfer: for each bit i, toggle rail[i][in_data[i]]; the other rail holds. Toggle phase. Go to WAIT_SET.
  - FP on transfer: set rail[i][in_data[i]]=1 and rail[i][!in_data[i]]=0. Go to WAIT_SET.
- WAIT_SET:
  - in_ready=0, busy=1.
  - TP: when ack_s==phase, go to IDLE.
  - FP: when ack_s==1, go to RTZ.
- RTZ (FP only): drive all link_data to 0 for one cycle, then go to WAIT_CLR.
- WAIT_CLR (FP only): when ack_s==0, go to IDLE.
- Round trip: minimum cycles from transfer to next in_ready=1 is SYNC_STAGES+2 for TP. Each extra ack edge for FP adds SYNC_STAGES+1.
- Timeout:
  - The counter clears on every state change and increments in each WAIT_* state.
  - At the count TIMEOUT-1, err is set. err stays set until reset.
  - The FSM keeps waiting; it never aborts a token.
- Stray ack:
  - Ack edges in IDLE are ignored for TP when ack_s==phase.
  - In TP IDLE, ack_s!=phase means a protocol violation: set err.
  - FP: ack_s==1 while IDLE sets err.
- in_data is sampled only on the transfer cycle. Later changes do not affect the token in flight.
- No buffering: at most one token is in flight. in_valid held high with constant data sends the same word repeatedly, one token per round trip.
- Reset mid-token: link_data returns to 0 immediately. This is the receiver's reset state, and the receiver is reset together with this block.

Test Plan:
- TP, WIDTH=1, SYNC_STAGES=2: send 1; ack toggles 0→1 three cycles after launch → link_data goes 00→10. in_ready drops for the round trip and returns 1 three cycles after the ack edge (two sync flops plus the state update). Next send 1 → link_data 10→00.
- TP, WIDTH=4: send 4'b1010, then 4'b1010 → after the first token link_data=8'b10011001. After the second it is all zeros, with phase returning to 0.
- FP, WIDTH=2: send 2'b01, receiver acks high then low → link_data 0000→0110→0000, one token. busy=1 from launch until WAIT_CLR sees ack_s==0.
- TIMEOUT=16, no ack: send any word → err=1 exactly 16 cycles after entering WAIT_SET. in_ready stays 0. A late ack then completes the token and err stays 1.
- Assert rst_n low in WAIT_SET with link_data nonzero → link_data=0, in_ready=0 and err=0 immediately without a clk edge. in_ready=1 one cycle after release.
- Back-to-back: in_valid held with words 0,1,2,3 (WIDTH=2, TP), ack echoing phase after 1 cycle → four tokens in order, and link_data decodes 0,1,2,3 by rail transitions.

Source files
------------

// File: rtl/link_sync_tx.sv
// link_sync_tx: clocked sender for the dual-rail self-timed link.
// Takes one word per valid/ready handshake and drives it as a dual-rail token,
// two-phase (transition) or four-phase (return-to-zero), completing each token
// on the synchronized receiver ack. Every output comes straight from a flop.
module link_sync_tx #(
  parameter string       ENC         = "TP",
  parameter int unsigned WIDTH       = 1,
  parameter int unsigned SYNC_STAGES = 2,
  parameter int unsigned TIMEOUT     = 1024
) (
  input  logic               clk,
  input  logic               rst_n,
  input  logic [WIDTH-1:0]   in_data,
  input  logic               in_valid,
  output logic               in_ready,
  output logic [2*WIDTH-1:0] link_data,
  input  logic               link_ack,
  output logic               busy,
  output logic               err
);

  localparam int unsigned LINK_W = 2 * WIDTH;
  localparam int unsigned CNT_W  = (TIMEOUT > 1) ? $clog2(TIMEOUT) : 1;
  localparam bit          IS_FP  = (ENC == "FP");
  localparam bit          TO_EN  = (TIMEOUT != 0);
  localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'((TIMEOUT > 0) ? (TIMEOUT - 1) : 32'd0);

  // Reject unsupported configurations at elaboration.
  if (!(ENC == "TP" || ENC == "FP")) begin : g_bad_enc
    $error("link_sync_tx: ENC must be \"TP\" or \"FP\"");
  end
  if (SYNC_STAGES < 2) begin : g_bad_sync
    $error("link_sync_tx: SYNC_STAGES must be at least 2");
  end

  typedef enum logic [1:0] {
    IDLE     = 2'd0,
    WAIT_SET = 2'd1,
    RTZ      = 2'd2,
    WAIT_CLR = 2'd3
  } state_e;

  state_e                 state_q, state_d;
  logic [SYNC_STAGES-1:0] sync_q, sync_d;
  logic [LINK_W-1:0]      link_q, link_d;
  logic [CNT_W-1:0]       cnt_q, cnt_d;
  logic                   phase_q, phase_d;
  logic                   err_q, err_d;
  logic                   in_ready_q, in_ready_d;
  logic                   busy_q, busy_d;

  logic                   ack_s;
  logic                   xfer;
  logic                   waiting;
  logic [LINK_W-1:0]      rail_mask;

  // One rail per bit carries the event: rail1 for a 1, rail0 for a 0.
  for (genvar i = 0; i < WIDTH; i++) begin : g_rail
    assign rail_mask[2*i]   = ~in_data[i];
    assign rail_mask[2*i+1] =  in_data[i];
  end

  assign ack_s   = sync_q[SYNC_STAGES-1];
  assign xfer    = in_valid & in_ready_q;
  assign waiting = (state_q == WAIT_SET) || (state_q == WAIT_CLR);

  // Ack synchronizer shift chain; only its last stage is ever consumed.
  always_comb begin
    sync_d = {sync_q[SYNC_STAGES-2:0], link_ack};
  end

  // State register.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= IDLE;
    end else begin
      state_q <= state_d;
    end
  end

  // Next-state logic: launch, then wait for the ack edge(s) the encoding needs.
  always_comb begin
    state_d = state_q;
    case (state_q)
      IDLE: begin
        if (xfer) state_d = WAIT_SET;
      end
      WAIT_SET: begin
        if (IS_FP) begin
          if (ack_s) state_d = RTZ;
        end else if (ack_s == phase_q) begin
          state_d = IDLE;
        end
      end
      RTZ: begin
        state_d = WAIT_CLR;
      end
      WAIT_CLR: begin
        if (!ack_s) state_d = IDLE;
      end
      default: begin
        state_d = IDLE;
      end
    endcase
  end

  // Output and datapath next values; handshake flags follow the next state.
  always_comb begin
    link_d     = link_q;
    phase_d    = phase_q;
    err_d      = err_q;
    cnt_d      = cnt_q;
    in_ready_d = (state_d == IDLE);
    busy_d     = (state_d != IDLE);

    if (xfer) begin
      if (IS_FP) begin
        link_d = rail_mask;
      end else begin
        link_d  = link_q ^ rail_mask;
        phase_d = ~phase_q;
      end
    end

    // Return-to-zero spacer launched as the set-phase ack is seen.
    if ((state_q == WAIT_SET) && (state_d == RTZ)) begin
      link_d = '0;
    end

    // Wait counter restarts on every state change and saturates at its limit.
    if (state_d != state_q) begin
      cnt_d = '0;
    end else if (waiting && (cnt_q != CNT_LAST)) begin
      cnt_d = cnt_q + CNT_W'(1);
    end

    if (TO_EN && waiting && (cnt_q == CNT_LAST)) begin
      err_d = 1'b1;
    end

    // An ack that disagrees with the idle link is a protocol violation.
    if (state_q == IDLE) begin
      if (IS_FP ? ack_s : (ack_s != phase_q)) err_d = 1'b1;
    end
  end

  // Datapath and output flops; link returns to zero as soon as reset asserts.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      sync_q     <= '0;
      link_q     <= '0;
      cnt_q      <= '0;
      phase_q    <= 1'b0;
      err_q      <= 1'b0;
      in_ready_q <= 1'b0;
      busy_q     <= 1'b0;
    end else begin
      sync_q     <= sync_d;
      link_q     <= link_d;
      cnt_q      <= cnt_d;
      phase_q    <= phase_d;
      err_q      <= err_d;
      in_ready_q <= in_ready_d;
      busy_q     <= busy_d;
    end
  end

  assign link_data = link_q;
  assign in_ready  = in_ready_q;
  assign busy      = busy_q;
  assign err       = err_q;

endmodule

// File: tb/tb_link_sync_tx.sv
// Bench for link_sync_tx: three instances (TP x1, TP x4 with short timeout,
// FP x2). Expected link words are queued at issue time and popped by monitors
// whenever a link changes; handshake timing is checked directly.
module tb_link_sync_tx;

  logic       clk;
  logic       rst_n;

  logic [0:0] a_data;
  logic       a_valid, a_ready, a_ack, a_busy, a_err;
  logic [1:0] a_link;

  logic [3:0] t_data;
  logic       t_valid, t_ready, t_ack, t_busy, t_err;
  logic [7:0] t_link;

  logic [1:0] f_data;
  logic       f_valid, f_ready, f_ack, f_busy, f_err;
  logic [3:0] f_link;

  int         vectors;
  int         miscompares;
  logic [7:0] tp_q[$];
  logic [3:0] fp_q[$];
  bit         t_resp_en;
  int         t_ack_dly;

  link_sync_tx #(.ENC("TP")) u_tp1 (
    .clk(clk), .rst_n(rst_n), .in_data(a_data), .in_valid(a_valid), .in_ready(a_ready),
    .link_data(a_link), .link_ack(a_ack), .busy(a_busy), .err(a_err)
  );

  link_sync_tx #(.ENC("TP"), .WIDTH(4), .SYNC_STAGES(2), .TIMEOUT(16)) u_tp (
    .clk(clk), .rst_n(rst_n), .in_data(t_data), .in_valid(t_valid), .in_ready(t_ready),
    .link_data(t_link), .link_ack(t_ack), .busy(t_busy), .err(t_err)
  );

  link_sync_tx #(.ENC("FP"), .WIDTH(2), .SYNC_STAGES(2), .TIMEOUT(16)) u_fp (
    .clk(clk), .rst_n(rst_n), .in_data(f_data), .in_valid(f_valid), .in_ready(f_ready),
    .link_data(f_link), .link_ack(f_ack), .busy(f_busy), .err(f_err)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    vectors++;
    if (act !== exp) begin
      miscompares++;
      $display("FAIL %s: got 0x%0h, expected 0x%0h", name, act, exp);
    end
  endtask

  function automatic logic ready_of(input int which);
    case (which)
      0:       return a_ready;
      1:       return t_ready;
      default: return f_ready;
    endcase
  endfunction

  // Poll in_ready once per cycle with a bound; an expired bound is a failure.
  task automatic wait_ready(input int which, input string name);
    int n;
    n = 0;
    while (ready_of(which) !== 1'b1 && n < 200) begin
      @(posedge clk); #1;
      n++;
    end
    if (ready_of(which) !== 1'b1) begin
      vectors++;
      miscompares++;
      $display("FAIL %s: in_ready still low after %0d cycles, expected 1", name, n);
    end
  endtask

  task automatic send_tp(input logic [3:0] d, input logic [7:0] exp_link);
    wait_ready(1, "tp_send_ready");
    t_data  = d;
    t_valid = 1'b1;
    tp_q.push_back(exp_link);
    @(posedge clk); #1;
    t_valid = 1'b0;
  endtask

  task automatic send_fp(input logic [1:0] d, input logic [3:0] exp_link);
    wait_ready(2, "fp_send_ready");
    f_data  = d;
    f_valid = 1'b1;
    fp_q.push_back(exp_link);
    fp_q.push_back(4'b0000);
    @(posedge clk); #1;
    f_valid = 1'b0;
  endtask

  // TP receiver: toggle ack a set number of cycles after each new token.
  initial begin
    logic [7:0] seen;
    seen  = '0;
    t_ack = 1'b0;
    forever begin
      @(negedge clk);
      if (!rst_n) begin
        seen  = '0;
        t_ack = 1'b0;
      end else if (t_resp_en && (t_link !== seen)) begin
        seen = t_link;
        repeat (t_ack_dly) @(negedge clk);
        t_ack = ~t_ack;
      end
    end
  end

  // FP receiver: ack follows data-valid / all-zero on the rails.
  initial begin
    f_ack = 1'b0;
    forever begin
      @(negedge clk);
      if (!rst_n) f_ack = 1'b0;
      else if ((f_link != 4'b0000) && !f_ack) f_ack = 1'b1;
      else if ((f_link == 4'b0000) && f_ack) f_ack = 1'b0;
    end
  end

  // Monitor: every TP link change must match the next queued word.
  initial begin
    logic [7:0] prev;
    logic [7:0] exp;
    prev = '0;
    forever begin
      @(negedge clk);
      if (!rst_n) begin
        prev = '0;
      end else if (t_link !== prev) begin
        if (tp_q.size() == 0) begin
          vectors++;
          miscompares++;
          $display("FAIL tp_link_unexpected: got 0x%0h, expected no change from 0x%0h", t_link, prev);
        end else begin
          exp = tp_q.pop_front();
          check("tp_link", 32'(t_link), 32'(exp));
        end
        prev = t_link;
      end
    end
  end

  // Monitor: every FP link change must match the next queued word.
  initial begin
    logic [3:0] prev;
    logic [3:0] exp;
    prev = '0;
    forever begin
      @(negedge clk);
      if (!rst_n) begin
        prev = '0;
      end else if (f_link !== prev) begin
        if (fp_q.size() == 0) begin
          vectors++;
          miscompares++;
          $display("FAIL fp_link_unexpected: got 0x%0h, expected no change from 0x%0h", f_link, prev);
        end else begin
          exp = fp_q.pop_front();
          check("fp_link", 32'(f_link), 32'(exp));
        end
        prev = f_link;
      end
    end
  end

  initial begin
    #200000;
    $display("FAIL watchdog: simulation exceeded time limit");
    $fatal(1, "watchdog");
  end

  initial begin
    int n;
    int gap;
    logic [3:0] b2b_w[4];
    logic [7:0] b2b_e[4];
    b2b_w = '{4'h0, 4'h1, 4'h2, 4'h3};
    b2b_e = '{8'h55, 8'h03, 8'h5A, 8'h00};

    vectors = 0; miscompares = 0;
    a_data = '0; a_valid = 1'b0; a_ack = 1'b0;
    t_data = '0; t_valid = 1'b0;
    f_data = '0; f_valid = 1'b0;
    t_resp_en = 1'b1; t_ack_dly = 0;
    rst_n = 1'b1;
    #2 rst_n = 1'b0;
    repeat (3) @(posedge clk);
    #1;
    check("rst_tp_link", 32'(t_link), 32'h0);
    check("rst_tp_ready", 32'(t_ready), 32'h0);
    check("rst_tp_busy", 32'(t_busy), 32'h0);
    check("rst_fp_err", 32'(f_err), 32'h0);
    rst_n = 1'b1;
    @(posedge clk); #1;
    check("rel_tp1_ready", 32'(a_ready), 32'h1);

    // TP x1: launch 1, ack edge, in_ready three cycles after the ack edge.
    a_data = 1'b1; a_valid = 1'b1;
    @(posedge clk); #1;
    a_valid = 1'b0;
    check("tp1_link_launch", 32'(a_link), 32'h2);
    check("tp1_ready_low", 32'(a_ready), 32'h0);
    check("tp1_busy_high", 32'(a_busy), 32'h1);
    repeat (2) @(posedge clk);
    #1 a_ack = 1'b1;
    repeat (2) @(posedge clk);
    #1;
    check("tp1_ready_hold", 32'(a_ready), 32'h0);
    @(posedge clk); #1;
    check("tp1_ready_back", 32'(a_ready), 32'h1);
    check("tp1_busy_low", 32'(a_busy), 32'h0);
    a_valid = 1'b1;
    @(posedge clk); #1;
    a_valid = 1'b0;
    check("tp1_link_second", 32'(a_link), 32'h0);
    a_ack = 1'b0;
    wait_ready(0, "tp1_second_ready");
    check("tp1_err_clean", 32'(a_err), 32'h0);

    // TP x1: stray ack edge while idle flags a protocol error.
    a_ack = 1'b1;
    repeat (2) @(posedge clk);
    #1;
    check("tp1_stray_err_early", 32'(a_err), 32'h0);
    @(posedge clk); #1;
    check("tp1_stray_err", 32'(a_err), 32'h1);
    a_ack = 1'b0;

    // TP x4: same word twice returns the rails to zero.
    send_tp(4'b1010, 8'b1001_1001);
    send_tp(4'b1010, 8'b0000_0000);
    wait_ready(1, "tp_pair_ready");

    // TP x4 back-to-back with in_valid held, ack one cycle late.
    t_ack_dly = 1;
    t_valid = 1'b1;
    for (int i = 0; i < 4; i++) begin
      t_data = b2b_w[i];
      wait_ready(1, "tp_b2b_ready");
      tp_q.push_back(b2b_e[i]);
      @(posedge clk); #1;
    end
    t_valid = 1'b0;
    wait_ready(1, "tp_b2b_done");
    check("tp_b2b_err", 32'(t_err), 32'h0);

    // FP x2: one token, busy across the whole four-phase round trip.
    wait_ready(2, "fp_first_ready");
    f_data = 2'b01; f_valid = 1'b1;
    fp_q.push_back(4'b0110);
    fp_q.push_back(4'b0000);
    @(posedge clk); #1;
    f_valid = 1'b0;
    check("fp_link_launch", 32'(f_link), 32'h6);
    n = 0; gap = 0;
    do begin
      if (f_busy !== 1'b1) gap++;
      @(posedge clk); #1;
      n++;
    end while (f_ready !== 1'b1 && n < 50);
    check("fp_busy_gap", 32'(gap), 32'h0);
    check("fp_round_trip", 32'(n), 32'd6);
    check("fp_busy_idle", 32'(f_busy), 32'h0);
    send_fp(2'b10, 4'b1001);
    send_fp(2'b11, 4'b1010);
    send_fp(2'b00, 4'b0101);
    wait_ready(2, "fp_done");
    check("fp_err_clean", 32'(f_err), 32'h0);

    // TP x4 timeout: no ack, err exactly 16 cycles into WAIT_SET.
    t_resp_en = 1'b0;
    wait_ready(1, "tp_to_ready");
    t_data = 4'b1111; t_valid = 1'b1;
    tp_q.push_back(8'hAA);
    @(posedge clk); #1;
    t_valid = 1'b0;
    repeat (15) @(posedge clk);
    #1;
    check("tp_to_err_early", 32'(t_err), 32'h0);
    check("tp_to_ready_low", 32'(t_ready), 32'h0);
    @(posedge clk); #1;
    check("tp_to_err_set", 32'(t_err), 32'h1);
    t_resp_en = 1'b1;
    wait_ready(1, "tp_late_ack_ready");
    check("tp_to_err_sticky", 32'(t_err), 32'h1);

    // Reset mid-token clears link, in_ready and err without a clock edge.
    t_resp_en = 1'b0;
    send_tp(4'b0000, 8'hFF);
    repeat (2) @(posedge clk);
    #3 rst_n = 1'b0;
    #1;
    check("rst_mid_link", 32'(t_link), 32'h0);
    check("rst_mid_ready", 32'(t_ready), 32'h0);
    check("rst_mid_err", 32'(t_err), 32'h0);
    check("rst_mid_busy", 32'(t_busy), 32'h0);
    @(posedge clk);
    #2 rst_n = 1'b1;
    check("rst_rel_ready_low", 32'(t_ready), 32'h0);
    @(posedge clk); #1;
    check("rst_rel_ready", 32'(t_ready), 32'h1);
    check("rst_rel_tp1_err", 32'(a_err), 32'h0);
    t_resp_en = 1'b1;

    repeat (4) @(posedge clk);
    #1;
    check("tp_queue_empty", 32'(tp_q.size()), 32'h0);
    check("fp_queue_empty", 32'(fp_q.size()), 32'h0);

    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule
